// File: rtl/blend_normalize_pkg.sv
// Shared widths, stage payload type and round/saturate helpers for blend_normalize.
package blend_normalize_pkg;

  localparam int unsigned BW_DEF       = 8;
  localparam int unsigned LINE_LEN_DEF = 16;

  // Widest channel the datapath helpers are sized for; BW must not exceed this.
  localparam int unsigned BW_MAX = 16;
  localparam int unsigned RW     = 2 * BW_MAX + 1;

  // S1 payload: rounded blend sum plus end-of-line marker.
  typedef struct packed {
    logic [RW-1:0] data;
    logic          last;
  } stage_t;

  // Add half an LSB of the output scale so the later shift rounds to nearest.
  function automatic logic [RW-1:0] round_bias(input logic [RW-1:0] d,
                                               input int unsigned   bw);
    return d + (RW'(1) << (bw - 1));
  endfunction

  // Drop the fractional bits and clamp to the largest bw-bit pixel value.
  function automatic logic [RW-1:0] sat_shift(input logic [RW-1:0] r,
                                              input int unsigned   bw);
    logic [RW-1:0] q;
    logic [RW-1:0] max_v;
    q     = r >> bw;
    max_v = (RW'(1) << bw) - RW'(1);
    return (q > max_v) ? max_v : q;
  endfunction

endpackage

// File: rtl/blend_pipe_reg.sv
// Valid/ready register slice: one payload entry, full throughput when downstream is ready.
module blend_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_c_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Accept when empty or when the held entry leaves this cycle.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    in_ready_c_o = !valid_q || out_ready_i;
    if (in_valid_i && in_ready_c_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slice state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/blend_normalize.sv
// Normalises a 2*BW blend sum to a rounded, saturated BW pixel over two
// register stages, and flags lines whose last marker disagrees with LINE_LEN.
module blend_normalize
  import blend_normalize_pkg::*;
#(
  parameter int unsigned BW       = BW_DEF,
  parameter int unsigned LINE_LEN = LINE_LEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*BW-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BW-1:0]   out_data,
  output logic            out_last,
  input  logic            err_clr,
  output logic            err_line
);

  localparam int unsigned S1W = $bits(stage_t);
  localparam int unsigned S2W = BW + 1;
  localparam int unsigned CW  = $clog2(LINE_LEN);

  stage_t         s1_d, s1_q;
  logic           s1_valid;
  logic           s2_ready_c;
  logic [S2W-1:0] s2_d, s2_q;

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           in_xfer_c, line_end_c;

  // S1 input: widen and add the rounding bias.
  always_comb begin
    s1_d      = '0;
    s1_d.data = round_bias(RW'(in_data), BW);
    s1_d.last = in_last;
  end

  blend_pipe_reg #(.W(S1W)) u_s1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_c_o (in_ready),
    .in_data_i    (s1_d),
    .out_valid_o  (s1_valid),
    .out_ready_i  (s2_ready_c),
    .out_data_o   (s1_q)
  );

  // S2 input: shift out the fraction and clamp, carrying last alongside.
  always_comb begin
    s2_d = {s1_q.last, BW'(sat_shift(s1_q.data, BW))};
  end

  blend_pipe_reg #(.W(S2W)) u_s2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (s1_valid),
    .in_ready_c_o (s2_ready_c),
    .in_data_i    (s2_d),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (s2_q)
  );

  assign out_data = s2_q[BW-1:0];
  assign out_last = s2_q[BW];

  // Pixel position tracking and sticky line-length error; clear wins over set.
  always_comb begin
    cnt_d      = cnt_q;
    err_d      = err_q;
    in_xfer_c  = in_valid && in_ready;
    line_end_c = (cnt_q == CW'(LINE_LEN - 1));
    if (in_xfer_c) begin
      cnt_d = (in_last || line_end_c) ? '0 : cnt_q + CW'(1);
    end
    if (err_clr) begin
      err_d = 1'b0;
    end else if (in_xfer_c && (in_last != line_end_c)) begin
      err_d = 1'b1;
    end
  end

  // Counter and error flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_line = err_q;

endmodule

// File: tb/tb_blend_normalize.sv
// Self-checking bench for blend_normalize (BW=8, LINE_LEN=16).
module tb_blend_normalize;

  localparam int BW = 8;
  localparam int LL = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*BW-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   out_data;
  logic            out_last;
  logic            err_clr;
  logic            err_line;

  always #5 clk = ~clk;

  blend_normalize #(.BW(BW), .LINE_LEN(LL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err_clr   (err_clr),
    .err_line  (err_line)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] din;
    logic        last;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: round to nearest of D / 2^BW, clamped to the pixel range.
  function automatic int ref_pix(input int d);
    int v;
    v = (d + (2 ** (BW - 1))) / (2 ** BW);
    if (v > (2 ** BW) - 1) v = (2 ** BW) - 1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [15:0] d, input logic l, input logic clr);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    err_clr  = clr;
    #2;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    err_clr  = 1'b0;
  endtask

  initial begin
    int exp_q[$];
    int sent, got, cyc, e;
    logic [15:0] cur_d;
    logic        cur_l;
    logic        hold, hl, in_fire, out_fire;
    logic [7:0]  hd;

    vt[0] = '{16'hFF00, 1'b0, 8'hFF};
    vt[1] = '{16'h7F80, 1'b0, 8'h80};
    vt[2] = '{16'h0000, 1'b0, 8'h00};
    vt[3] = '{16'h0080, 1'b0, 8'h01};
    vt[4] = '{16'h007F, 1'b0, 8'h00};
    vt[5] = '{16'hFFFF, 1'b0, 8'hFF};
    vt[6] = '{16'h1234, 1'b1, 8'h12};
    vt[7] = '{16'hFF7F, 1'b0, 8'hFF};

    // Reset values before any clock edge.
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_err_line", 32'(err_line), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors with exact two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].din;
      in_last  = vt[i].last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 16'(($urandom));
      chk($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].exp_data));
      chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vt[i].last));
      tick();
    end

    // Random stream under a 1,0,0 out_ready pattern against a queue model.
    do_reset();
    sent  = 0;
    got   = 0;
    cyc   = 0;
    hold  = 1'b0;
    hd    = '0;
    hl    = 1'b0;
    cur_d = 16'($urandom);
    cur_l = 1'b0;
    while (got < 40 && cyc < 2000) begin
      out_ready = (cyc % 3 == 0);
      cur_l     = ((sent % LL) == LL - 1);
      if (sent < 40 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = cur_d;
        in_last  = cur_l;
      end else begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
      end
      #2;
      if (hold) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(hd));
        chk("stall_last", 32'(out_last), 32'(hl));
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", 32'(out_data), 32'(e & 'hFF));
          chk("stream_last", 32'(out_last), 32'(e >> 8));
        end
        got++;
      end
      hold = out_valid && !out_ready;
      hd   = out_data;
      hl   = out_last;
      if (in_fire) begin
        exp_q.push_back(ref_pix(int'(cur_d)) | (int'(cur_l) << 8));
        sent++;
        cur_d = 16'($urandom);
      end
      tick();
      cyc++;
    end
    idle_inputs();
    chk("stream_count", 32'(got), 32'd40);
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);
    chk("stream_err_line", 32'(err_line), 32'd0);

    // Line-length checking and sticky error behaviour.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < LL; i++) send_beat(16'($urandom), (i == LL - 1), 1'b0);
    chk("line_ok", 32'(err_line), 32'd0);
    for (int i = 0; i < 10; i++) begin
      send_beat(16'($urandom), (i == 9), 1'b0);
      if (i == 8) chk("err_before_early_last", 32'(err_line), 32'd0);
    end
    chk("err_early_last", 32'(err_line), 32'd1);
    repeat (3) tick();
    chk("err_sticky", 32'(err_line), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_line), 32'd0);
    send_beat(16'($urandom), 1'b1, 1'b1);
    chk("err_clr_priority", 32'(err_line), 32'd0);
    for (int i = 0; i < LL - 1; i++) send_beat(16'($urandom), 1'b0, 1'b0);
    chk("err_before_missing_last", 32'(err_line), 32'd0);
    send_beat(16'($urandom), 1'b0, 1'b0);
    chk("err_missing_last", 32'(err_line), 32'd1);

    // Asynchronous reset with both stages full, then a clean line.
    do_reset();
    out_ready = 1'b0;
    send_beat(16'h4000, 1'b0, 1'b0);
    send_beat(16'h8000, 1'b0, 1'b0);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_out_data", 32'(out_data), 32'h40);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_err_line", 32'(err_line), 32'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < LL; i++) send_beat(16'($urandom), (i == LL - 1), 1'b0);
    chk("post_rst_line_ok", 32'(err_line), 32'd0);
    tick();
    chk("post_rst_out_last", 32'(out_last), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
